// File: rtl/pc_branch_sequencer.sv
// Fetch-stage PC sequencer: advances the PC under the imem handshake and
// redirects on taken branches, squashing wrong-path IF/ID for a fixed window.
module pc_branch_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_valid,
    input  logic              br_take,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_req,
    output logic              flush,
    output logic              misalign_err,
    output logic [15:0]       taken_cnt
);

    typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

    state_t            state, state_next;
    logic [3:0]        flush_cnt, flush_cnt_next;
    logic [ADDR_W-1:0] pc_next;
    logic              fetch_req_next;
    logic              flush_next;
    logic              misalign_next;
    logic [15:0]       taken_cnt_next;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= INIT;
            flush_cnt    <= '0;
            pc           <= RESET_PC;
            fetch_req    <= 1'b0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
            taken_cnt    <= '0;
        end else begin
            state        <= state_next;
            flush_cnt    <= flush_cnt_next;
            pc           <= pc_next;
            fetch_req    <= fetch_req_next;
            flush        <= flush_next;
            misalign_err <= misalign_next;
            taken_cnt    <= taken_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        pc_next        = pc;
        fetch_req_next = fetch_req;
        flush_next     = flush;
        misalign_next  = 1'b0;
        taken_cnt_next = taken_cnt;

        case (state)
            INIT: begin
                state_next     = RUN;
                fetch_req_next = 1'b1;
                flush_next     = 1'b0;
            end
            RUN: begin
                fetch_req_next = 1'b1;
                // A taken redirect wins over stall and memory back-pressure.
                if (br_valid && br_take) begin
                    state_next     = FLUSH;
                    pc_next        = {br_target[ADDR_W-1:2], 2'b00};
                    flush_next     = 1'b1;
                    fetch_req_next = 1'b0;
                    flush_cnt_next = 4'(FLUSH_CYCLES - 1);
                    misalign_next  = (br_target[1:0] != 2'b00);
                    taken_cnt_next = sat_inc(taken_cnt);
                end else if (!stall && imem_ready) begin
                    pc_next = pc + ADDR_W'(4);
                end
            end
            FLUSH: begin
                // Everything in flight is wrong-path, so all inputs are ignored.
                if (flush_cnt == 4'd0) begin
                    state_next     = RUN;
                    flush_next     = 1'b0;
                    fetch_req_next = 1'b1;
                end else begin
                    flush_cnt_next = flush_cnt - 4'd1;
                end
            end
            default: begin
                state_next     = INIT;
                fetch_req_next = 1'b0;
                flush_next     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Bench for pc_branch_sequencer: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural model of the fetch PC.
module tb_pc_branch_sequencer;

    localparam int          FLUSH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_take = 1'b0;
    logic [31:0] br_target = '0;
    logic        imem_ready = 1'b1;
    logic [31:0] pc;
    logic        fetch_req;
    logic        flush;
    logic        misalign_err;
    logic [15:0] taken_cnt;

    int errors = 0;
    int checks = 0;

    pc_branch_sequencer #(
        .ADDR_W(32),
        .RESET_PC(RST_PC),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .br_valid(br_valid),
        .br_take(br_take),
        .br_target(br_target),
        .imem_ready(imem_ready),
        .pc(pc),
        .fetch_req(fetch_req),
        .flush(flush),
        .misalign_err(misalign_err),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch unit should be presenting after each edge.
    logic [31:0] m_pc;
    logic        m_fr, m_fl, m_mis;
    logic [15:0] m_cnt;
    int          m_left;
    bit          m_init;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_fr = 0; m_fl = 0; m_mis = 0; m_cnt = 0;
            m_left = 0; m_init = 1; m_ok = 1;
        end else if (m_ok) begin
            m_mis = 0;
            if (m_init) begin
                m_init = 0;
                m_fr = 1;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_fl = 0;
                    m_fr = 1;
                end
            end else if (br_valid && br_take) begin
                m_pc   = br_target & 32'hFFFF_FFFC;
                m_fl   = 1;
                m_fr   = 0;
                m_mis  = (br_target % 4) != 0;
                m_left = FLUSH;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end else if (!stall && imem_ready) begin
                m_pc = m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("pc", pc, m_pc);
            chk("fetch_req", 32'(fetch_req), 32'(m_fr));
            chk("flush", 32'(flush), 32'(m_fl));
            chk("misalign_err", 32'(misalign_err), 32'(m_mis));
            chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
        end
    end

    task automatic step(input logic r, input logic s, input logic rdy,
                        input logic bv, input logic bt, input logic [31:0] t);
        rst_n = r; stall = s; imem_ready = rdy;
        br_valid = bv; br_take = bt; br_target = t;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 1, 0, 0, 32'h0);
    endtask

    task automatic taken(input logic [31:0] t);
        step(1, 0, 1, 1, 1, t);
    endtask

    initial begin
        @(negedge clk);
        #1;
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetch_req", 32'(fetch_req), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_taken_cnt", 32'(taken_cnt), 32'h0);

        for (int i = 0; i < 5; i++) begin
            idle();
            chk("seq_pc", pc, 32'(i * 4));
            chk("seq_fetch_req", 32'(fetch_req), 32'h1);
        end
        repeat (4) idle();
        chk("pre_br_pc", pc, 32'h20);

        taken(32'h100);
        chk("br_pc", pc, 32'h100);
        chk("br_flush1", 32'(flush), 32'h1);
        chk("br_fetch_req", 32'(fetch_req), 32'h0);
        chk("br_taken_cnt", 32'(taken_cnt), 32'h1);
        idle();
        chk("br_flush2", 32'(flush), 32'h1);
        idle();
        chk("br_flush_end", 32'(flush), 32'h0);
        chk("br_refetch", 32'(fetch_req), 32'h1);
        chk("br_refetch_pc", pc, 32'h100);
        idle();
        chk("br_next_pc", pc, 32'h104);

        step(1, 1, 0, 1, 1, 32'h40);
        chk("stall_br_pc", pc, 32'h40);
        chk("stall_br_flush", 32'(flush), 32'h1);
        repeat (4) idle();
        chk("nt_pre_pc", pc, 32'h48);
        step(1, 0, 1, 1, 0, 32'h900);
        chk("nt_pc", pc, 32'h4C);
        chk("nt_taken_cnt", 32'(taken_cnt), 32'h2);

        taken(32'h203);
        chk("mis_pc", pc, 32'h200);
        chk("mis_pulse", 32'(misalign_err), 32'h1);
        taken(32'h500);
        chk("mis_clear", 32'(misalign_err), 32'h0);
        chk("flush_ign_pc", pc, 32'h200);
        taken(32'h600);
        chk("lastflush_ign_pc", pc, 32'h200);
        chk("lastflush_fetch", 32'(fetch_req), 32'h1);
        chk("flush_ign_cnt", 32'(taken_cnt), 32'h3);

        taken(32'h10);
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0);
            chk("nrdy_pc", pc, 32'h10);
            chk("nrdy_fetch", 32'(fetch_req), 32'h1);
        end
        idle();
        chk("nrdy_adv", pc, 32'h14);

        taken(32'hFFFF_FFFC);
        idle();
        idle();
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", pc, 32'h0);

        taken(32'h80);
        chk("rstflush_flush", 32'(flush), 32'h1);
        step(0, 0, 1, 0, 0, 0);
        chk("rstflush_pc", pc, RST_PC);
        chk("rstflush_flush0", 32'(flush), 32'h0);
        chk("rstflush_cnt", 32'(taken_cnt), 32'h0);
        chk("rstflush_fetch", 32'(fetch_req), 32'h0);
        idle();
        chk("rstflush_init_done", 32'(fetch_req), 32'h1);

        force dut.taken_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1;
        release dut.taken_cnt;
        for (int i = 0; i < 3; i++) begin
            taken(32'h300 + 32'(i * 16));
            idle();
            idle();
        end
        chk("sat_cnt", 32'(taken_cnt), 32'hFFFF);

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 1'($urandom_range(0, 1)), t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
Program-counter sequencer and branch-redirect controller for the RISC core fetch stage. It consumes the registered taken/not-taken decision from the branch decision unit in EX, together with the branch target. It advances the PC and handshakes fetches with instruction memory. On a taken branch it redirects the PC and squashes the wrong-path fetch/decode stages for a fixed number of cycles.

Parameters:
ADDR_W, 32, PC/target width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, cycles flush is held after a redirect. Legal range is 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
stall  input  1  hazard-unit stall; hold PC while high.
br_valid  input  1  branch decision valid this cycle (branch/jump instruction in EX).
br_take  input  1  branch decision output; 1 = taken. Qualified by br_valid.
br_target  input  ADDR_W  branch/jump target address.
imem_ready  input  1  instruction memory accepts the current fetch.
pc  output  ADDR_W  current fetch address, registered.
fetch_req  output  1  fetch request to instruction memory, registered.
flush  output  1  squash IF/ID stage contents, registered.
misalign_err  output  1  one-cycle pulse: taken target had br_target[1:0] != 0.
taken_cnt  output  16  saturating count of taken branches, registered.

Behaviour:
- Reset:
  - Applies when rst_n=0 at a clk edge, in any state, including mid-FLUSH.
  - Values: pc=RESET_PC, fetch_req=0, flush=0, misalign_err=0, taken_cnt=0, state=INIT, flush counter=0.
- States are INIT, RUN and FLUSH.
- INIT:
  - Entered for exactly one cycle after reset is released.
  - Next state RUN with fetch_req=1; pc stays RESET_PC.
  - br_valid is ignored in INIT.
- RUN, evaluated in priority order each edge:
  1. Taken branch (br_valid=1, br_take=1):
     - pc <= {br_target[ADDR_W-1:2], 2'b00}.
     - flush <= 1, fetch_req <= 0.
     - flush counter <= FLUSH_CYCLES-1.
     - misalign_err <= (br_target[1:0] != 0).
     - taken_cnt <= taken_cnt+1, saturating at 16'hFFFF.
     - Next state FLUSH.
     - The taken branch overrides stall and imem_ready.
  2. Stall (stall=1): pc held, fetch_req held at 1.
  3. Memory not ready (imem_ready=0): pc held, fetch_req held at 1. The request stays stable until accepted.
  4. Otherwise pc <= pc+4, modulo 2^ADDR_W. At pc=2^ADDR_W-4 it wraps to 0 with no flag.
  - br_valid=1 with br_take=0 has no effect (predict not-taken).
- FLUSH:
  - flush=1, fetch_req=0, pc held at target.
  - br_valid, stall and imem_ready are ignored; the in-flight instructions are wrong-path.
  - The counter decrements each cycle. At counter=0 the next edge gives state RUN, flush=0, fetch_req=1.
- Latency:
  - A decision sampled at edge N gives the new pc, flush=1 and misalign_err after edge N.
  - flush stays high for exactly FLUSH_CYCLES cycles.
  - fetch_req for the target rises on the edge after the last flush cycle.
  - Minimum taken-branch penalty is FLUSH_CYCLES+1 fetch slots.
- Branch outcome on the final flush cycle: ignored. A genuine branch cannot be in EX then, because all younger instructions are flushed.
- misalign_err: one-cycle pulse only. The trap path acts on it; this block does not halt.
- Outputs are glitch-free; every output is driven from a flop.

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1, stall=0 for 6 cycles → one INIT cycle with fetch_req=0, then pc = 0, 4, 8, 12, 16 with fetch_req=1.
- At pc=0x20, br_valid=1, br_take=1, br_target=0x100 → next cycle:
  - pc=0x100, flush=1 for 2 cycles, fetch_req=0.
  - Third cycle fetch_req=1, pc=0x100; next pc 0x104.
  - taken_cnt=1.
- Taken branch with stall=1 and imem_ready=0 in the same cycle, target 0x40 → redirect still occurs: pc=0x40, flush=1. Then br_valid=1, br_take=0 at a later pc 0x48 → pc advances to 0x4C, taken_cnt unchanged.
- br_target=0x203 taken → pc=0x200, misalign_err=1 for exactly one cycle. A second br_valid/br_take pulse during FLUSH is ignored: pc remains 0x200 and taken_cnt increments only once.
- imem_ready=0 for 3 cycles at pc=0x10 → pc=0x10 and fetch_req=1 held. Advances to 0x14 one cycle after imem_ready returns. pc=0xFFFF_FFFC advances to 0x0000_0000.
- Reset (rst_n=0) asserted on the first FLUSH cycle → next edge gives pc=RESET_PC, flush=0, taken_cnt=0, INIT. Separately, forcing taken_cnt=16'hFFFE and issuing 3 taken branches → taken_cnt=16'hFFFF (saturates).
